aes_rt_checker: RTL and testbench

- Parametrised round-trip self-test controller for the AES encrypt/decrypt pair.
- Assembles an NBYTES-byte plaintext block from a byte stream and presents it to the external encrypt→decrypt chain.
- Waits a fixed, parameterised round-trip latency, then compares the decrypted block against the plaintext.
- Reports pass/fail and keeps saturating pass/fail tallies. Successor to the single-shot switch/pushbutton loopback top: handles any block width, has an abort input and gives explicit status.

---
 rtl/aes_rt_pkg.sv | 24 ++
 rtl/aes_rt_edge_sync.sv | 21 ++
 rtl/aes_rt_checker.sv | 156 +++++++++++++++
 tb/tb_aes_rt_checker.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_rt_pkg.sv
// Shared types and helpers for the AES round-trip self-test controller.
package aes_rt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    RESULT = 3'd4
  } rtState_e;

  localparam int AES_BLK_W = 128;

  // Ceiling log2 usable in constant expressions (port and counter widths).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_rt_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector: one pulse per raw level rise.
module aes_rt_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [2:0] syncSh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncSh <= '0;
    end else begin
      syncSh <= {syncSh[1:0], din};
    end
  end

  assign pulse = syncSh[1] & ~syncSh[2];

endmodule

// File: rtl/aes_rt_checker.sv
// Round-trip self-test controller: assembles a plaintext block, waits RT_LAT, compares.
// Build option AES_RT_CHECKER_SYNC_EN treats byte_valid as a raw pushbutton level.
//
// state  | meaning
// IDLE   | empty block, accepting the first byte
// LOAD   | block partially assembled
// WAIT   | pt_out stable, round-trip latency counting down
// CHECK  | compare dec_in against pt_out
// RESULT | pass/fail held; next byte starts a new block
module aes_rt_checker
  import aes_rt_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int RT_LAT = 22,
  parameter int CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  input  logic                           abort,
  input  logic [8*NBYTES-1:0]            dec_in,
  output logic                           ready,
  output logic [8*NBYTES-1:0]            pt_out,
  output logic [clog2(NBYTES+1)-1:0]     byte_cnt,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic [CNT_W-1:0]               pass_cnt,
  output logic [CNT_W-1:0]               fail_cnt
);

  localparam int BW  = 8 * NBYTES;
  localparam int CW  = clog2(NBYTES + 1);
  localparam int WCW = (clog2(RT_LAT) > 0) ? clog2(RT_LAT) : 1;

  rtState_e       state, stateNext;
  logic [BW-1:0]  ptNext;
  logic [CW-1:0]  cntNext;
  logic [WCW-1:0] waitCnt, waitNext;
  logic           doneNext, passNext, failNext;
  logic           passInc, failInc;
  logic           validEff;

`ifdef AES_RT_CHECKER_SYNC_EN
  aes_rt_edge_sync uEdgeSync (
    .clk   (clk),
    .rst   (rst),
    .din   (byte_valid),
    .pulse (validEff)
  );
`else
  assign validEff = byte_valid;
`endif

  assign ready = (state == IDLE) || (state == LOAD) || (state == RESULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptNext    = pt_out;
    cntNext   = byte_cnt;
    waitNext  = waitCnt;
    doneNext  = 1'b0;
    passNext  = pass;
    failNext  = fail;
    passInc   = 1'b0;
    failInc   = 1'b0;

    if (abort) begin
      stateNext = IDLE;
      ptNext    = '0;
      cntNext   = '0;
      waitNext  = '0;
      passNext  = 1'b0;
      failNext  = 1'b0;
    end else begin
      case (state)
        IDLE, RESULT: begin
          if (validEff) begin
            ptNext   = BW'(byte_in);
            cntNext  = CW'(1);
            passNext = 1'b0;
            failNext = 1'b0;
            if (NBYTES == 1) begin
              stateNext = WAIT;
              waitNext  = WCW'(RT_LAT - 1);
            end else begin
              stateNext = LOAD;
            end
          end
        end
        LOAD: begin
          if (validEff) begin
            ptNext  = (pt_out << 8) | BW'(byte_in);
            cntNext = byte_cnt + 1'b1;
            if (byte_cnt == CW'(NBYTES - 1)) begin
              stateNext = WAIT;
              waitNext  = WCW'(RT_LAT - 1);
            end
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            stateNext = CHECK;
          end else begin
            waitNext = waitCnt - 1'b1;
          end
        end
        CHECK: begin
          doneNext  = 1'b1;
          stateNext = RESULT;
          if (dec_in == pt_out) begin
            passNext = 1'b1;
            passInc  = 1'b1;
          end else begin
            failNext = 1'b1;
            failInc  = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pt_out   <= '0;
      byte_cnt <= '0;
      waitCnt  <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      pt_out   <= ptNext;
      byte_cnt <= cntNext;
      waitCnt  <= waitNext;
      done     <= doneNext;
      pass     <= passNext;
      fail     <= failNext;
      // tallies saturate at all-ones
      if (passInc && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
      if (failInc && (fail_cnt != '1)) fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_rt_checker.sv
// Self-checking bench for aes_rt_checker: default-parameter instance plus a small saturating one.
module tb_aes_rt_checker;

  localparam int NB   = 16;
  localparam int LAT  = 22;
  localparam int BW   = 8 * NB;
  localparam int NB2  = 2;
  localparam int LAT2 = 3;
  localparam int BW2  = 8 * NB2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    byteIn = '0;
  logic          byteValid = 1'b0;
  logic          abortIn = 1'b0;
  logic [BW-1:0] decIn;
  logic          ready, done, pass, fail;
  logic [BW-1:0] ptOut;
  logic [4:0]    byteCnt;
  logic [7:0]    passCnt, failCnt;
  logic [BW-1:0] flipMask = '0;
  logic [BW-1:0] chain [LAT];

  logic [7:0]     sByteIn = '0;
  logic           sValid = 1'b0;
  logic           sAbort = 1'b0;
  logic [BW2-1:0] sDec;
  logic           sReady, sDone, sPass, sFail;
  logic [BW2-1:0] sPt;
  logic [1:0]     sCnt;
  logic [1:0]     sPassCnt, sFailCnt;
  logic [BW2-1:0] chainS [LAT2];

  int checks = 0;
  int failures = 0;
  int expPass = 0;
  int expFail = 0;

  aes_rt_checker dut (
    .clk(clk), .rst(rst), .byte_in(byteIn), .byte_valid(byteValid), .abort(abortIn),
    .dec_in(decIn), .ready(ready), .pt_out(ptOut), .byte_cnt(byteCnt), .done(done),
    .pass(pass), .fail(fail), .pass_cnt(passCnt), .fail_cnt(failCnt)
  );

  aes_rt_checker #(.NBYTES(NB2), .RT_LAT(LAT2), .CNT_W(2)) dutS (
    .clk(clk), .rst(rst), .byte_in(sByteIn), .byte_valid(sValid), .abort(sAbort),
    .dec_in(sDec), .ready(sReady), .pt_out(sPt), .byte_cnt(sCnt), .done(sDone),
    .pass(sPass), .fail(sFail), .pass_cnt(sPassCnt), .fail_cnt(sFailCnt)
  );

  // External encrypt->decrypt chain modelled as a pure RT_LAT-cycle delay of pt_out.
  always @(posedge clk) begin
    chain[0] <= ptOut;
    for (int i = 1; i < LAT; i++) chain[i] <= chain[i-1];
    chainS[0] <= sPt;
    for (int i = 1; i < LAT2; i++) chainS[i] <= chainS[i-1];
  end
  assign decIn = chain[LAT-1] ^ flipMask;
  assign sDec  = chainS[LAT2-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (done) seen = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (ptOut !== '0 || byteCnt !== '0) begin
      failures++;
      $display("FAIL reset_data: pt_out=%h byte_cnt=%0d required 0/0", ptOut, byteCnt);
    end
    checks++;
    if ({ready, done, pass, fail} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_status: rdy/done/pass/fail=%b required 1000", {ready, done, pass, fail});
    end
    checks++;
    if (passCnt !== 8'd0 || failCnt !== 8'd0 || sPassCnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_tally: pass_cnt=%0d fail_cnt=%0d required 0/0", passCnt, failCnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

`ifndef AES_RT_CHECKER_SYNC_EN

  task automatic sendByte(input logic [7:0] b);
    byteIn = b;
    byteValid = 1'b1;
    tick();
    byteValid = 1'b0;
  endtask

  task automatic loadBlock(input logic [7:0] bytes [NB], input int gapMax, output logic [BW-1:0] pt);
    pt = '0;
    for (int i = 0; i < NB; i++) begin
      repeat ($urandom_range(gapMax, 0)) tick();
      sendByte(bytes[i]);
      pt = (pt << 8) | BW'(bytes[i]);
    end
  endtask

  task automatic runBlock(input string name, input logic [7:0] bytes [NB], input int gapMax);
    logic [BW-1:0] pt;
    int n;
    bit seen;
    bit expOk;
    loadBlock(bytes, gapMax, pt);
    expOk = (flipMask == '0);
    checks++;
    if (ptOut !== pt || byteCnt !== 5'd16 || ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_load: pt_out=%h cnt=%0d rdy=%b required %h/16/0", name, ptOut, byteCnt, ready, pt);
    end
    waitDone(n, seen);
    checks++;
    if (!seen || n != LAT + 1) begin
      failures++;
      $display("FAIL %s_latency: done after %0d cycles (seen=%0d) required %0d", name, n, seen, LAT + 1);
    end
    if (expOk) expPass = (expPass < 255) ? expPass + 1 : 255;
    else       expFail = (expFail < 255) ? expFail + 1 : 255;
    checks++;
    if (pass !== expOk || fail !== !expOk) begin
      failures++;
      $display("FAIL %s_result: pass=%b fail=%b required %b/%b", name, pass, fail, expOk, !expOk);
    end
    checks++;
    if (passCnt !== 8'(expPass) || failCnt !== 8'(expFail)) begin
      failures++;
      $display("FAIL %s_tally: pass_cnt=%0d fail_cnt=%0d required %0d/%0d", name, passCnt, failCnt, expPass, expFail);
    end
    tick();
    checks++;
    if (done !== 1'b0 || pass !== expOk || ptOut !== pt) begin
      failures++;
      $display("FAIL %s_hold: done=%b pass=%b pt_out=%h required 0/%b/%h", name, done, pass, ptOut, expOk, pt);
    end
  endtask

  task automatic test_basic_pass();
    logic [7:0] bytes [NB];
    for (int i = 0; i < NB; i++) bytes[i] = 8'(i * 17);
    flipMask = '0;
    runBlock("basic", bytes, 0);
    checks++;
    if (ptOut !== 128'h00112233445566778899aabbccddeeff) begin
      failures++;
      $display("FAIL basic_vector: pt_out=%h required 00112233445566778899aabbccddeeff", ptOut);
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] bytes [NB];
    logic [BW-1:0] pt;
    int pulses;
    for (int i = 0; i < NB; i++) bytes[i] = 8'(i * 17);
    flipMask = BW'(1);
    loadBlock(bytes, 0, pt);
    pulses = 0;
    repeat (LAT + 8) begin
      tick();
      if (done) pulses++;
    end
    expFail++;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL mismatch_pulses: done pulses=%0d required 1", pulses);
    end
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || failCnt !== 8'(expFail) || passCnt !== 8'(expPass)) begin
      failures++;
      $display("FAIL mismatch_result: fail=%b pass=%b fail_cnt=%0d pass_cnt=%0d required 1/0/%0d/%0d",
               fail, pass, failCnt, passCnt, expFail, expPass);
    end
    flipMask = '0;
  endtask

  task automatic test_random_blocks();
    logic [7:0] bytes [NB];
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
      flipMask = ($urandom_range(1, 0) == 1) ? (BW'(1) << $urandom_range(BW - 1, 0)) : '0;
      runBlock("random", bytes, 3);
    end
    flipMask = '0;
  endtask

  task automatic test_busy_drop();
    logic [7:0] bytes [NB];
    logic [BW-1:0] pt;
    logic [7:0] nb;
    int n;
    bit seen;
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
    loadBlock(bytes, 0, pt);
    byteValid = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      byteIn = 8'($urandom);
      tick();
      n++;
      if (done) begin
        seen = 1;
      end else begin
        checks++;
        if (ready !== 1'b0 || ptOut !== pt || byteCnt !== 5'd16) begin
          failures++;
          $display("FAIL busy_hold: rdy=%b pt_out=%h cnt=%0d required 0/%h/16", ready, ptOut, byteCnt, pt);
        end
      end
    end
    checks++;
    if (!seen || n != LAT + 1) begin
      failures++;
      $display("FAIL busy_latency: done after %0d cycles required %0d", n, LAT + 1);
    end
    expPass++;
    nb = 8'($urandom);
    byteIn = nb;
    tick();
    byteValid = 1'b0;
    checks++;
    if (byteCnt !== 5'd1 || ptOut !== BW'(nb) || pass !== 1'b0 || fail !== 1'b0 || passCnt !== 8'(expPass)) begin
      failures++;
      $display("FAIL busy_restart: cnt=%0d pt_out=%h pass=%b fail=%b pass_cnt=%0d required 1/%h/0/0/%0d",
               byteCnt, ptOut, pass, fail, passCnt, BW'(nb), expPass);
    end
  endtask

  task automatic test_abort();
    logic [BW-1:0] pt;
    logic [7:0] bytes [NB];
    int pulses;
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    pt = '0;
    for (int i = 0; i < 7; i++) begin
      bytes[i] = 8'($urandom);
      sendByte(bytes[i]);
      pt = (pt << 8) | BW'(bytes[i]);
    end
    checks++;
    if (byteCnt !== 5'd7 || ptOut !== pt) begin
      failures++;
      $display("FAIL abort_partial: cnt=%0d pt_out=%h required 7/%h", byteCnt, ptOut, pt);
    end
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    checks++;
    if (byteCnt !== '0 || ptOut !== '0 || {ready, done, pass, fail} !== 4'b1000 ||
        passCnt !== 8'(expPass) || failCnt !== 8'(expFail)) begin
      failures++;
      $display("FAIL abort_clear: cnt=%0d pt_out=%h status=%b tallies=%0d/%0d required 0/0/1000/%0d/%0d",
               byteCnt, ptOut, {ready, done, pass, fail}, passCnt, failCnt, expPass, expFail);
    end
    abortIn = 1'b1;
    byteValid = 1'b1;
    byteIn = 8'h5a;
    tick();
    abortIn = 1'b0;
    byteValid = 1'b0;
    tick();
    checks++;
    if (byteCnt !== '0 || ptOut !== '0) begin
      failures++;
      $display("FAIL abort_priority: cnt=%0d pt_out=%h required 0/0", byteCnt, ptOut);
    end
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
    loadBlock(bytes, 0, pt);
    repeat (4) tick();
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    pulses = 0;
    repeat (LAT + 6) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0 || ptOut !== '0 || ready !== 1'b1 || passCnt !== 8'(expPass)) begin
      failures++;
      $display("FAIL abort_wait: pulses=%0d pt_out=%h rdy=%b pass_cnt=%0d required 0/0/1/%0d",
               pulses, ptOut, ready, passCnt, expPass);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] bytes [NB];
    logic [BW-1:0] pt;
    int pulses;
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
    loadBlock(bytes, 1, pt);
    repeat (5) tick();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (ptOut !== '0 || byteCnt !== '0 || {ready, done, pass, fail} !== 4'b1000 ||
        passCnt !== 8'd0 || failCnt !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: pt_out=%h cnt=%0d status=%b tallies=%0d/%0d required 0/0/1000/0/0",
               ptOut, byteCnt, {ready, done, pass, fail}, passCnt, failCnt);
    end
    expPass = 0;
    expFail = 0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (LAT + 6) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL async_no_done: pulses=%0d rdy=%b required 0/1", pulses, ready);
    end
  endtask

  task automatic test_saturation();
    logic [BW2-1:0] pt;
    logic [7:0] b;
    int n;
    int expS;
    bit seen;
    expS = 0;
    for (int blk = 0; blk < 5; blk++) begin
      pt = '0;
      for (int i = 0; i < NB2; i++) begin
        b = 8'($urandom);
        sByteIn = b;
        sValid = 1'b1;
        tick();
        pt = (pt << 8) | BW2'(b);
      end
      sValid = 1'b0;
      n = 0;
      seen = 0;
      while (!seen && n < 50) begin
        tick();
        n++;
        if (sDone) seen = 1;
      end
      expS = (expS < 3) ? expS + 1 : 3;
      checks++;
      if (!seen || n != LAT2 + 1 || sPt !== pt || sPass !== 1'b1 || sPassCnt !== 2'(expS) || sFailCnt !== 2'd0) begin
        failures++;
        $display("FAIL saturation: blk=%0d n=%0d pt=%h pass=%b pass_cnt=%0d required n=%0d pt=%h pass=1 cnt=%0d",
                 blk, n, sPt, sPass, sPassCnt, LAT2 + 1, pt, expS);
      end
    end
  endtask

`else

  task automatic test_sync_pulse();
    logic [BW-1:0] pt;
    logic [4:0] last;
    logic [7:0] b;
    int changes, at, doneAt;
    pt = '0;
    doneAt = 0;
    for (int p = 0; p < NB; p++) begin
      b = 8'($urandom);
      pt = (pt << 8) | BW'(b);
      byteIn = b;
      byteValid = 1'b1;
      last = byteCnt;
      changes = 0;
      at = 0;
      for (int c = 1; c <= 50; c++) begin
        tick();
        if (byteCnt !== last) begin
          changes++;
          if (at == 0) at = c;
          last = byteCnt;
        end
        if (done && doneAt == 0) doneAt = c;
      end
      byteValid = 1'b0;
      repeat (5) tick();
      checks++;
      if (changes != 1 || at != 3) begin
        failures++;
        $display("FAIL sync_accept: pulse=%0d accepts=%0d at_cycle=%0d required 1 at 3", p, changes, at);
      end
    end
    checks++;
    if (ptOut !== pt || pass !== 1'b1 || passCnt !== 8'd1 || doneAt != 3 + LAT + 1) begin
      failures++;
      $display("FAIL sync_block: pt_out=%h pass=%b pass_cnt=%0d done_at=%0d required %h/1/1/%0d",
               ptOut, pass, passCnt, doneAt, pt, 3 + LAT + 1);
    end
  endtask

`endif

  initial begin
    test_reset();
`ifdef AES_RT_CHECKER_SYNC_EN
    test_sync_pulse();
`else
    test_basic_pass();
    test_mismatch();
    test_random_blocks();
    test_busy_drop();
    test_abort();
    test_async_reset();
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
